cpu_trace_emitter: RTL and testbench

//  Serialises one CPU write-back record per handshake into the ASCII trace stream consumed by the trace checker, one char per accepted beat.
//  Reg record: "^<time>@<pc>:<sp>$<grf> <= <data>#". Mem record: "^<time>@<pc>:<sp>*<addr> <= <data>#".

---
 rtl/cpu_trace_emitter_pkg.sv | 31 +++
 rtl/cpu_trace_bin2dec.sv | 31 +++
 rtl/cpu_trace_emitter.sv | 189 ++++++++++++++++++
 tb/tb_cpu_trace_emitter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_emitter_pkg.sv
// rtl/cpu_trace_emitter_pkg.sv - shared widths, ASCII codes, FSM states and nibble-to-ASCII helper
package cpu_trace_emitter_pkg;

  localparam int TIME_W = 14;
  localparam int GRF_W  = 5;

  localparam logic [7:0] ASC_CARET  = 8'h5E;
  localparam logic [7:0] ASC_AT     = 8'h40;
  localparam logic [7:0] ASC_COLON  = 8'h3A;
  localparam logic [7:0] ASC_DOLLAR = 8'h24;
  localparam logic [7:0] ASC_STAR   = 8'h2A;
  localparam logic [7:0] ASC_LT     = 8'h3C;
  localparam logic [7:0] ASC_EQ     = 8'h3D;
  localparam logic [7:0] ASC_HASH   = 8'h23;
  localparam logic [7:0] ASC_SPACE  = 8'h20;
  localparam logic [7:0] ASC_LF     = 8'h0A;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CARET, ST_TIME, ST_AT, ST_PC, ST_COLON, ST_SPACE, ST_MARK,
    ST_OPER, ST_SP_A, ST_LT, ST_EQ, ST_SP_B, ST_DATA, ST_HASH
`ifdef TRACE_EMITTER_NEWLINE_EN
    , ST_NL
`endif
  } state_t;

  // Also serves decimal digits, which are always below ten.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h57 + {4'd0, n});
  endfunction

endpackage

// File: rtl/cpu_trace_bin2dec.sv
// rtl/cpu_trace_bin2dec.sv - combinational double-dabble, 14-bit binary to 4 BCD digits plus digit count
module cpu_trace_bin2dec
  import cpu_trace_emitter_pkg::*;
(
  input  logic [TIME_W-1:0] bin,
  output logic [15:0]       bcd,
  output logic [2:0]        ndig
);

  logic [TIME_W+15:0] sh;

  always_comb begin
    sh = {16'd0, bin};
    for (int i = 0; i < TIME_W; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sh[TIME_W+4*d +: 4] > 4'd4)
          sh[TIME_W+4*d +: 4] = sh[TIME_W+4*d +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    bcd = sh[TIME_W +: 16];
  end

  always_comb begin
    if (bcd[15:12] != 4'd0)     ndig = 3'd4;
    else if (bcd[11:8] != 4'd0) ndig = 3'd3;
    else if (bcd[7:4] != 4'd0)  ndig = 3'd2;
    else                        ndig = 3'd1;
  end

endmodule

// File: rtl/cpu_trace_emitter.sv
// rtl/cpu_trace_emitter.sv - serialises CPU write-back records into an ASCII trace char stream
// Optional trailing LF per record when TRACE_EMITTER_NEWLINE_EN is defined.
module cpu_trace_emitter
  import cpu_trace_emitter_pkg::*;
#(
  parameter int TIME_MAX    = 9999,
  parameter int LEAD_SPACES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_mem,
  input  logic [TIME_W-1:0] in_time,
  input  logic [31:0]       in_pc,
  input  logic [GRF_W-1:0]  in_grf,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       in_data,
  output logic [7:0]        char,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              busy,
  output logic              drop
);

  localparam logic [TIME_W:0] TIME_LIM = (TIME_W+1)'(TIME_MAX);

  state_t             state_q, nxt_state;
  logic [3:0]         cnt_q, nxt_cnt, len;
  logic               last;
  logic               is_mem_q;
  logic [31:0]        pc_q, addr_q, data_q;
  logic [GRF_W-1:0]   grf_q;
  logic [15:0]        time_bcd_q, grf_bcd_unused_hi;
  logic [2:0]         time_nd_q;
  logic [7:0]         grf_bcd_q;
  logic [1:0]         grf_nd_q;
  logic [TIME_W-1:0]  conv_in;
  logic [15:0]        conv_bcd;
  logic [2:0]         conv_nd;
  logic [7:0]         nchar;
  logic [1:0]         tidx;
  logic               gidx;
  logic [2:0]         hidx;

  // One converter: time while idle (captured at accept), grf afterwards (captured entering MARK).
  assign conv_in = (state_q == ST_IDLE) ? in_time : {{(TIME_W-GRF_W){1'b0}}, grf_q};

  cpu_trace_bin2dec u_bin2dec (
    .bin  (conv_in),
    .bcd  (conv_bcd),
    .ndig (conv_nd)
  );

  assign grf_bcd_unused_hi = conv_bcd;
  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);

  function automatic state_t follow(input state_t s);
    case (s)
      ST_CARET: return ST_TIME;
      ST_TIME:  return ST_AT;
      ST_AT:    return ST_PC;
      ST_PC:    return ST_COLON;
      ST_COLON: return (LEAD_SPACES == 0) ? ST_MARK : ST_SPACE;
      ST_SPACE: return ST_MARK;
      ST_MARK:  return ST_OPER;
      ST_OPER:  return ST_SP_A;
      ST_SP_A:  return ST_LT;
      ST_LT:    return ST_EQ;
      ST_EQ:    return ST_SP_B;
      ST_SP_B:  return ST_DATA;
      ST_DATA:  return ST_HASH;
`ifdef TRACE_EMITTER_NEWLINE_EN
      ST_HASH:  return ST_NL;
`endif
      default:  return ST_IDLE;
    endcase
  endfunction

  always_comb begin
    len = 4'd1;
    case (state_q)
      ST_TIME:         len = {1'b0, time_nd_q};
      ST_PC, ST_DATA:  len = 4'd8;
      ST_OPER:         len = is_mem_q ? 4'd8 : {2'b00, grf_nd_q};
      ST_SPACE:        len = 4'(LEAD_SPACES);
      default:         len = 4'd1;
    endcase
  end

  assign last = (cnt_q == len - 4'd1);

  always_comb begin
    nxt_state = state_q;
    nxt_cnt   = cnt_q + 4'd1;
    if (state_q == ST_IDLE) begin
      nxt_state = ST_CARET;
      nxt_cnt   = 4'd0;
    end else if (last) begin
      nxt_state = follow(state_q);
      nxt_cnt   = 4'd0;
    end
  end

  // Digit indices are MSB-first; modular arithmetic on the narrow slices is exact here.
  assign tidx = time_nd_q[1:0] - 2'd1 - nxt_cnt[1:0];
  assign gidx = grf_nd_q[0] ^ 1'b1 ^ nxt_cnt[0];
  assign hidx = ~nxt_cnt[2:0];

  always_comb begin
    nchar = 8'h00;
    case (nxt_state)
      ST_CARET: nchar = ASC_CARET;
      ST_TIME:  nchar = hex_char(time_bcd_q[{tidx, 2'b00} +: 4]);
      ST_AT:    nchar = ASC_AT;
      ST_PC:    nchar = hex_char(pc_q[{hidx, 2'b00} +: 4]);
      ST_COLON: nchar = ASC_COLON;
      ST_SPACE, ST_SP_A, ST_SP_B: nchar = ASC_SPACE;
      ST_MARK:  nchar = is_mem_q ? ASC_STAR : ASC_DOLLAR;
      ST_OPER:  nchar = is_mem_q ? hex_char(addr_q[{hidx, 2'b00} +: 4])
                                 : hex_char(grf_bcd_q[{gidx, 2'b00} +: 4]);
      ST_LT:    nchar = ASC_LT;
      ST_EQ:    nchar = ASC_EQ;
      ST_DATA:  nchar = hex_char(data_q[{hidx, 2'b00} +: 4]);
      ST_HASH:  nchar = ASC_HASH;
`ifdef TRACE_EMITTER_NEWLINE_EN
      ST_NL:    nchar = ASC_LF;
`endif
      default:  nchar = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      char       <= 8'h00;
      char_valid <= 1'b0;
      drop       <= 1'b0;
      is_mem_q   <= 1'b0;
      pc_q       <= 32'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      grf_q      <= '0;
      time_bcd_q <= 16'd0;
      time_nd_q  <= 3'd0;
      grf_bcd_q  <= 8'd0;
      grf_nd_q   <= 2'd0;
    end else begin
      drop <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (in_valid) begin
          is_mem_q   <= in_is_mem;
          pc_q       <= in_pc;
          addr_q     <= in_addr;
          data_q     <= in_data;
          grf_q      <= in_grf;
          time_bcd_q <= grf_bcd_unused_hi;
          time_nd_q  <= conv_nd;
          if ({1'b0, in_time} > TIME_LIM) begin
            drop <= 1'b1;
          end else begin
            state_q    <= ST_CARET;
            cnt_q      <= 4'd0;
            char       <= ASC_CARET;
            char_valid <= 1'b1;
          end
        end
      end else if (char_valid && char_ready) begin
        if (nxt_state == ST_IDLE) begin
          state_q    <= ST_IDLE;
          cnt_q      <= 4'd0;
          char       <= 8'h00;
          char_valid <= 1'b0;
        end else begin
          state_q <= nxt_state;
          cnt_q   <= nxt_cnt;
          char    <= nchar;
          if (nxt_state == ST_MARK) begin
            grf_bcd_q <= conv_bcd[7:0];
            grf_nd_q  <= conv_nd[1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// tb/tb_cpu_trace_emitter.sv - directed self-checking bench for cpu_trace_emitter
module tb_cpu_trace_emitter;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_mem;
  logic [13:0] in_time;
  logic [31:0] in_pc;
  logic [4:0]  in_grf;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [7:0]  ch;
  logic        char_valid;
  logic        char_ready;
  logic        busy;
  logic        drop;

  int          n_checks = 0;
  int          n_errors = 0;
  int          lf_cnt = 0;
  int          recs_done = 0;
  bit          rdy_rand = 0;
  logic [7:0]  rx_q[$];

  cpu_trace_emitter dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_is_mem  (in_is_mem),
    .in_time    (in_time),
    .in_pc      (in_pc),
    .in_grf     (in_grf),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .char       (ch),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .busy       (busy),
    .drop       (drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    char_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      char_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Collects accepted beats and verifies the char is held while stalled.
  initial begin
    bit         hold_pend;
    logic [7:0] prev_c;
    hold_pend = 0;
    prev_c = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (hold_pend) begin
          check("hold_valid", char_valid, 1);
          check("hold_char", ch, prev_c);
        end
        if (char_valid && char_ready) begin
          rx_q.push_back(ch);
          if (ch == 8'h0A) lf_cnt++;
        end
        hold_pend = char_valid && !char_ready;
        prev_c = ch;
      end else begin
        hold_pend = 0;
      end
    end
  end

  task automatic offer(input logic m, input logic [13:0] t, input logic [31:0] pc,
                       input logic [31:0] op, input logic [31:0] d);
    int g;
    g = 0;
    while (!in_ready && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("offer_ready_timeout", (g >= 200), 0);
    in_valid  = 1'b1;
    in_is_mem = m;
    in_time   = t;
    in_pc     = pc;
    in_grf    = op[4:0];
    in_addr   = op;
    in_data   = d;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_is_mem = ($urandom_range(0, 1) == 1);
    in_time   = 14'($urandom_range(0, 16383));
    in_pc     = $urandom;
    in_grf    = 5'($urandom_range(0, 31));
    in_addr   = $urandom;
    in_data   = $urandom;
  endtask

  task automatic run_record(input string tag, input logic m, input logic [13:0] t,
                            input logic [31:0] pc, input logic [31:0] op,
                            input logic [31:0] d, input bit rnd);
    string exp;
    int    n;
    if (m) exp = $sformatf("^%0d@%08h: *%08h <= %08h#", t, pc, op, d);
    else   exp = $sformatf("^%0d@%08h: $%0d <= %08h#", t, pc, op[4:0], d);
`ifdef TRACE_EMITTER_NEWLINE_EN
    exp = {exp, "\n"};
`endif
    rx_q.delete();
    rdy_rand = rnd;
    offer(m, t, pc, op, d);
    check({tag, "_busy"}, busy, 1);
    n = 0;
    while (!in_ready && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    rdy_rand = 0;
    check({tag, "_timeout"}, (n >= 3000), 0);
    if (!rnd) check({tag, "_cycles"}, n, exp.len());
    check({tag, "_len"}, rx_q.size(), exp.len());
    for (int i = 0; i < exp.len(); i++) begin
      if (i < rx_q.size()) check($sformatf("%s_c%0d", tag, i), rx_q[i], exp[i]);
    end
    recs_done++;
  endtask

  initial begin
    int g;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_is_mem = 1'b0;
    in_time   = '0;
    in_pc     = '0;
    in_grf    = '0;
    in_addr   = '0;
    in_data   = '0;
    #3;
    check("rst_char", ch, 8'h00);
    check("rst_valid", char_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_drop", drop, 0);
    #20;
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_record("rec1", 1'b0, 14'd12, 32'h0000_3000, 32'd5, 32'hdead_beef, 0);
    run_record("rec2", 1'b1, 14'd0, 32'h0000_3004, 32'h0000_0010, 32'h0000_0001, 0);
    run_record("rec3", 1'b0, 14'd12, 32'h0000_3000, 32'd5, 32'hdead_beef, 1);
    run_record("rec4", 1'b0, 14'd9999, 32'h1234_5678, 32'd31, 32'h89ab_cdef, 0);
    run_record("rec5", 1'b0, 14'd305, 32'hffff_fffc, 32'd0, 32'h0000_0000, 1);

    offer(1'b0, 14'd10000, 32'h0000_4000, 32'd7, 32'h1111_2222);
    check("drop_pulse", drop, 1);
    check("drop_in_ready", in_ready, 1);
    check("drop_valid", char_valid, 0);
    check("drop_busy", busy, 0);
    @(posedge clk);
    #1;
    check("drop_clear", drop, 0);
    check("drop_no_char", char_valid, 0);

    rx_q.delete();
    offer(1'b0, 14'd12, 32'h0000_3000, 32'd5, 32'hdead_beef);
    g = 0;
    while (rx_q.size() < 6 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("rst_mid_count", rx_q.size(), 6);
    check("rst_mid_pre_valid", char_valid, 1);
    reset = 1'b0;
    #1;
    check("rst_mid_valid", char_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    run_record("rec6", 1'b1, 14'd137, 32'habcd_ef01, 32'hfedc_ba98, 32'h0000_0000, 0);

`ifdef TRACE_EMITTER_NEWLINE_EN
    check("lf_count", lf_cnt, recs_done);
`else
    check("lf_count", lf_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
